// File: rtl/mem_read_sequencer.sv
// mem_read_sequencer: issues a burst of reads to a 1-cycle-latency synchronous
// memory and streams the returned words through a 2-entry valid/ready buffer.
// Reads are throttled so buffered plus in-flight words never exceed the buffer.
module mem_read_sequencer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int BUF_D  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t                   state, state_nx;
  logic [ADDR_W-1:0]        base_r, len_r, cnt;
  entry_t [BUF_D-1:0]       ent_q;
  logic [1:0]               occ;
  logic                     inflight, inflight_last;
  logic                     pop, push, last_issue;
  entry_t                   new_ent;

  assign pop        = out_valid & out_ready;
  assign push       = inflight;
  assign last_issue = rd_en && (cnt == len_r - ADDR_W'(1));
  assign new_ent    = '{last: inflight_last, data: rd_data};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (len != '0) ? READ : DONE;
      READ:    if (last_issue) state_nx = DRAIN;
      DRAIN:   if (pop && ent_q[0].last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state; reads issue only while the buffer can absorb them
  always_comb begin
    busy  = (state == READ) || (state == DRAIN);
    done  = (state == DONE);
    rd_en = (state == READ) &&
            (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
  end

  assign rd_addr   = base_r + cnt;
  assign out_valid = (occ != 2'd0);
  assign out_data  = ent_q[0].data;
  assign out_last  = ent_q[0].last & out_valid;

  // Burst parameter capture and read counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_r <= '0;
      len_r  <= '0;
      cnt    <= '0;
    end else if (state == IDLE && start) begin
      base_r <= base_addr;
      len_r  <= len;
      cnt    <= '0;
    end else if (rd_en) begin
      cnt <= cnt + ADDR_W'(1);
    end
  end

  // Tracks the read whose data returns next cycle, tagged if it is the final one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= last_issue;
    end
  end

  // Two-entry buffer; entry 0 is always the head presented on out_*
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_q <= '0;
      occ   <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          ent_q[occ[0]] <= new_ent;
          occ           <= occ + 2'd1;
        end
        2'b01: begin
          ent_q[0] <= ent_q[1];
          occ      <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            ent_q[0] <= new_ent;
          end else begin
            ent_q[0] <= ent_q[1];
            ent_q[1] <= new_ent;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_read_sequencer.sv
// Bench for mem_read_sequencer: directed bursts with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_read_sequencer;

  localparam int AW = 5;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, out_ready;
  logic [AW-1:0] base_addr, len;
  logic          busy, done, rd_en, out_valid, out_last;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, out_data;

  logic [DW-1:0] mem [32];

  int checks = 0;
  int errors = 0;

  // model state (transaction level: counts of issued/delivered/popped words)
  int phase = 0;          // 0 idle, 1 burst active, 2 done cycle
  int m_base = 0, m_len = 0;
  int issued = 0, delivered = 0, popped = 0;
  int just_reset = 0;
  int chk_en = 0;
  int rden_seen = 0;
  int cyc = 0;

  mem_read_sequencer #(.ADDR_W(AW), .DATA_W(DW), .BUF_D(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // synchronous memory with one cycle of read latency
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model and per-cycle compare
  initial begin
    int ev, er, pop;
    forever begin
      @(negedge clk);
      cyc++;
      ev  = (phase == 1 && delivered > popped) ? 1 : 0;
      pop = (ev != 0 && out_ready) ? 1 : 0;
      er  = (phase == 1 && issued < m_len && (issued - popped - pop) < 2) ? 1 : 0;
      if (chk_en != 0) begin
        chk("busy", int'(busy), (phase == 1) ? 1 : 0);
        chk("done", int'(done), (phase == 2) ? 1 : 0);
        chk("rd_en", int'(rd_en), er);
        chk("out_valid", int'(out_valid), ev);
        if (er != 0) chk("rd_addr", int'(rd_addr), (m_base + issued) % 32);
        if (ev != 0) begin
          chk("out_data", int'(out_data), int'(mem[(m_base + popped) % 32]));
          chk("out_last", int'(out_last), (popped == m_len - 1) ? 1 : 0);
        end
        if (just_reset != 0) begin
          chk("rst_rd_addr", int'(rd_addr), 0);
          chk("rst_out_data", int'(out_data), 0);
          chk("rst_out_last", int'(out_last), 0);
        end
      end
      if (rd_en === 1'b1) rden_seen++;
      if (!rst_n) begin
        phase = 0; issued = 0; delivered = 0; popped = 0; just_reset = 1;
      end else begin
        just_reset = 0;
        case (phase)
          0: if (start) begin
            m_base = int'(base_addr); m_len = int'(len);
            issued = 0; delivered = 0; popped = 0;
            phase = (len != '0) ? 1 : 2;
          end
          1: begin
            if (pop != 0 && popped == m_len - 1) phase = 2;
            delivered = issued;
            issued    = issued + er;
            popped    = popped + pop;
          end
          default: phase = 0;
        endcase
      end
    end
  end

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (phase == 0 && start == 1'b0) break;
      tick();
    end
    if (i == budget) chk("wait_idle_timeout", 1, 0);
  endtask

  // 4-word burst with every address and data word given literally
  task automatic burst4(input int b, input int a0, a1, a2, a3, d0, d1, d2, d3);
    int ea [4];
    int ed [4];
    ea = '{a0, a1, a2, a3};
    ed = '{d0, d1, d2, d3};
    base_addr = AW'(b); len = AW'(4); start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("lit_rd_en_T", int'(rd_en), 0);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        chk("lit_rd_en", int'(rd_en), 1);
        chk("lit_rd_addr", int'(rd_addr), ea[c-1]);
      end
      if (c >= 3 && c <= 6) begin
        chk("lit_out_valid", int'(out_valid), 1);
        chk("lit_out_data", int'(out_data), ed[c-3]);
        chk("lit_out_last", int'(out_last), (c == 6) ? 1 : 0);
      end
      chk("lit_done", int'(done), (c == 7) ? 1 : 0);
      tick();
    end
  endtask

  initial begin
    for (int a = 0; a < 32; a++) mem[a] = DW'(a + 100);
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_rd_en", int'(rd_en), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_rd_addr", int'(rd_addr), 0);
    chk("reset_out_data", int'(out_data), 0);
    tick();

    // 1: basic burst timing
    burst4(3, 3, 4, 5, 6, 103, 104, 105, 106);
    wait_idle(50);
    // 2: address wrap
    burst4(30, 30, 31, 0, 1, 130, 131, 100, 101);
    wait_idle(50);

    // 3: backpressure holds the head and caps outstanding reads
    base_addr = AW'(8); len = AW'(6); start = 1'b1; out_ready = 1'b0;
    rden_seen = 0;
    tick(); start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    @(negedge clk);
    chk("bp_rd_count", rden_seen, 2);
    chk("bp_out_valid", int'(out_valid), 1);
    chk("bp_out_data", int'(out_data), 108);
    tick(); out_ready = 1'b1;
    wait_idle(50);

    // 4: zero-length burst
    base_addr = AW'(5); len = '0; start = 1'b1;
    tick(); start = 1'b0;
    @(negedge clk);
    chk("len0_done", int'(done), 1);
    chk("len0_busy", int'(busy), 0);
    chk("len0_rd_en", int'(rd_en), 0);
    tick();
    wait_idle(10);

    // 5: start while busy is ignored
    base_addr = AW'(12); len = AW'(5); start = 1'b1;
    tick();
    base_addr = AW'(1); len = AW'(9);
    tick(); tick(); start = 1'b0;
    wait_idle(50);

    // 6: reset mid-burst, then a clean burst
    base_addr = AW'(10); len = AW'(8); start = 1'b1; rden_seen = 0;
    tick(); start = 1'b0;
    for (int i = 0; i < 20 && rden_seen < 3; i++) tick();
    chk("rst_mid_reached", (rden_seen >= 3) ? 1 : 0, 1);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_out_valid", int'(out_valid), 0);
    chk("rst_mid_rd_en", int'(rd_en), 0);
    tick();
    base_addr = AW'(20); len = AW'(3); start = 1'b1;
    tick(); start = 1'b0;
    wait_idle(50);

    // randomized traffic
    for (int a = 0; a < 32; a++) mem[a] = DW'($urandom);
    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom_range(0, 5) == 0);
      base_addr = AW'($urandom);
      len       = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 6));
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 400) != 0);
      tick();
    end
    start = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    wait_idle(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
